// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and defaults for the hazard scoreboard.
//   state_e     : controller states (RUN, WAIT, ERR)
//   TIMEOUT_DEF : default number of WAIT cycles tolerated before ERR
//   CNT_W_DEF   : default width of the stall performance counter
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/hazard_wdog.sv
// -----------------------------------------------------------------------------
// hazard_wdog
// Watchdog counter for data-memory WAIT cycles.
// Ports:
//   clk_i      : clock, rising edge
//   rst_n_i    : synchronous active-low reset
//   cnt_en_i   : count one more WAIT cycle without acknowledge
//   clr_i      : clear the count (has priority over cnt_en_i)
//   expired_o  : count has reached TIMEOUT-1; one more unacknowledged
//                cycle means the access has timed out
// -----------------------------------------------------------------------------
module hazard_wdog
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic cnt_en_i,
  input  logic clr_i,
  output logic expired_o
);

  // One extra code point so the count can step past TIMEOUT-1 on the
  // cycle the controller moves to ERR without wrapping.
  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// data-memory freeze with timeout watchdog.
// Ports:
//   clk_i, rst_n_i          : clock (rising edge), synchronous active-low reset
//   ID_RS1addr_i/RS2addr_i  : source registers of the instruction in ID
//   ID_valid_i              : ID holds a real instruction
//   ID_EX_MemRead_i         : instruction in EX is a load
//   ID_EX_RDaddr_i          : destination register of the instruction in EX
//   Branch_i                : taken branch resolved in ID
//   Dmem_req_i, Dmem_ack_i  : MEM-stage access request / completion
//   PC_Write_o              : PC update enable
//   IF_ID_Write_o           : IF/ID register write enable
//   NoOp_o                  : insert a bubble into ID/EX
//   Flush_o                 : clear IF/ID
//   Freeze_o                : hold every pipeline register
//   Err_o                   : sticky memory timeout flag
//   Stall_cnt_o             : saturating count of cycles with PC_Write_o==0
// Build option:
//   HAZARD_PERF_CNT_EN      : when defined, the stall counter is built;
//                             otherwise Stall_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       ID_RS1addr_i,
  input  logic [4:0]       ID_RS2addr_i,
  input  logic             ID_valid_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RDaddr_i,
  input  logic             Branch_i,
  input  logic             Dmem_req_i,
  input  logic             Dmem_ack_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             Freeze_o,
  output logic             Err_o,
  output logic [CNT_W-1:0] Stall_cnt_o
);

  state_e state_q;
  logic   err_q;
  logic   hazard;
  logic   freeze;
  logic   wd_en, wd_clr, wd_expired;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  always_comb begin
    hazard = ID_valid_i && ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
             ((ID_EX_RDaddr_i == ID_RS1addr_i) || (ID_EX_RDaddr_i == ID_RS2addr_i));
  end

  // Freeze is combinational so the pipeline holds in the very cycle the
  // memory fails to acknowledge, not one cycle late.
  always_comb begin
    case (state_q)
      RUN:     freeze = Dmem_req_i && !Dmem_ack_i;
      WAIT:    freeze = !Dmem_ack_i;
      default: freeze = 1'b1;
    endcase
  end

  assign wd_en  = (state_q == WAIT) && !Dmem_ack_i;
  assign wd_clr = (state_q != WAIT) || Dmem_ack_i;

  hazard_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .cnt_en_i  (wd_en),
    .clr_i     (wd_clr),
    .expired_o (wd_expired)
  );

  // Controller FSM; ERR is left only through reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (Dmem_req_i && !Dmem_ack_i) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (Dmem_ack_i) begin
            state_q <= RUN;
          end else if (wd_expired) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  // Priority: freeze, then load-use stall, then branch flush. A branch that
  // collides with a stall is not flushed; ID is held and the branch is
  // presented again next cycle.
  always_comb begin
    PC_Write_o    = 1'b1;
    IF_ID_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    Flush_o       = 1'b0;
    if (freeze) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
    end else if (hazard) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
      NoOp_o        = 1'b1;
    end else if (Branch_i) begin
      Flush_o       = 1'b1;
    end
  end

  assign Freeze_o = freeze;
  assign Err_o    = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturates at all-ones so a long freeze never reads back as a small count.
  always_comb begin
    stall_d = stall_q;
    if (!PC_Write_o && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign Stall_cnt_o = stall_q;
`else
  assign Stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int TO = 255;
  localparam int CW = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, rd;
  logic          vld, mrd, br, req, ack;
  logic          pcw, ifw, noop, flush, frz, err;
  logic [CW-1:0] stall;
  logic [5:0]    outs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .ID_RS1addr_i    (rs1),
    .ID_RS2addr_i    (rs2),
    .ID_valid_i      (vld),
    .ID_EX_MemRead_i (mrd),
    .ID_EX_RDaddr_i  (rd),
    .Branch_i        (br),
    .Dmem_req_i      (req),
    .Dmem_ack_i      (ack),
    .PC_Write_o      (pcw),
    .IF_ID_Write_o   (ifw),
    .NoOp_o          (noop),
    .Flush_o         (flush),
    .Freeze_o        (frz),
    .Err_o           (err),
    .Stall_cnt_o     (stall)
  );

  // {PC_Write, IF_ID_Write, NoOp, Flush, Freeze, Err}
  assign outs = {pcw, ifw, noop, flush, frz, err};

  function automatic logic [CW-1:0] ex_st(input int n);
    return PERF ? CW'(n) : '0;
  endfunction

  // Apply inputs just after a falling edge and let them settle.
  task automatic drive(input logic v, input logic m, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] d,
                       input logic b, input logic rq, input logic ak);
    @(negedge clk);
    vld = v; mrd = m; rs1 = a1; rs2 = a2; rd = d; br = b; req = rq; ack = ak;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vld = 0; mrd = 0; rs1 = 0; rs2 = 0; rd = 0; br = 0; req = 0; ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (outs !== 6'b110000) begin
      n_bad++; $display("FAIL reset_outs: got %b expected %b", outs, 6'b110000);
    end
    n_cmp++;
    if (stall !== '0) begin
      n_bad++; $display("FAIL reset_stall: got %0d expected 0", stall);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (outs !== 6'b110000) begin
        n_bad++; $display("FAIL reset_idle: got %b expected %b", outs, 6'b110000);
      end
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1, 1, 5'd1, 5'd5, 5'd5, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b001000 || stall !== ex_st(0)) begin
      n_bad++; $display("FAIL load_use_rs2: got %b/%0d expected %b/%0d", outs, stall, 6'b001000, ex_st(0));
    end
    drive(1, 0, 5'd1, 5'd5, 5'd5, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000 || stall !== ex_st(1)) begin
      n_bad++; $display("FAIL load_use_release: got %b/%0d expected %b/%0d", outs, stall, 6'b110000, ex_st(1));
    end
    drive(1, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b001000) begin
      n_bad++; $display("FAIL load_use_rs1: got %b expected %b", outs, 6'b001000);
    end
    drive(0, 1, 5'd7, 5'd7, 5'd7, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000 || stall !== ex_st(2)) begin
      n_bad++; $display("FAIL load_use_invalid: got %b/%0d expected %b/%0d", outs, stall, 6'b110000, ex_st(2));
    end
  endtask

  task automatic test_x0_branch();
    apply_reset();
    drive(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000) begin
      n_bad++; $display("FAIL x0_no_stall: got %b expected %b", outs, 6'b110000);
    end
    drive(1, 0, 5'd3, 5'd4, 5'd3, 1, 0, 0);
    n_cmp++;
    if (outs !== 6'b110100) begin
      n_bad++; $display("FAIL branch_flush: got %b expected %b", outs, 6'b110100);
    end
    drive(1, 0, 5'd3, 5'd4, 5'd3, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000 || stall !== ex_st(0)) begin
      n_bad++; $display("FAIL branch_one_cycle: got %b/%0d expected %b/%0d", outs, stall, 6'b110000, ex_st(0));
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (outs !== 6'b000010) begin
        n_bad++; $display("FAIL freeze_wait%0d: got %b expected %b", i, outs, 6'b000010);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    n_cmp++;
    if (outs !== 6'b110000 || stall !== ex_st(3)) begin
      n_bad++; $display("FAIL freeze_ack: got %b/%0d expected %b/%0d", outs, stall, 6'b110000, ex_st(3));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000) begin
      n_bad++; $display("FAIL freeze_back_run: got %b expected %b", outs, 6'b110000);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    // One RUN cycle plus TO unacknowledged WAIT cycles before ERR.
    for (int i = 0; i <= TO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (outs !== 6'b000010) begin
        n_bad++; $display("FAIL timeout_wait%0d: got %b expected %b", i, outs, 6'b000010);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'd2, 5'd2, 5'd2, 1, 1'(i), 1);
      n_cmp++;
      if (outs !== 6'b000011) begin
        n_bad++; $display("FAIL timeout_err%0d: got %b expected %b", i, outs, 6'b000011);
      end
    end
    apply_reset();
    n_cmp++;
    if (outs !== 6'b110000 || stall !== '0) begin
      n_bad++; $display("FAIL timeout_reset: got %b/%0d expected %b/0", outs, stall, 6'b110000);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000) begin
      n_bad++; $display("FAIL timeout_run: got %b expected %b", outs, 6'b110000);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    drive(1, 1, 5'd3, 5'd0, 5'd3, 1, 1, 0);
    n_cmp++;
    if (outs !== 6'b000010) begin
      n_bad++; $display("FAIL prio_freeze: got %b expected %b", outs, 6'b000010);
    end
    drive(1, 1, 5'd3, 5'd0, 5'd3, 1, 0, 1);
    n_cmp++;
    if (outs !== 6'b001000) begin
      n_bad++; $display("FAIL prio_stall: got %b expected %b", outs, 6'b001000);
    end
    drive(1, 0, 5'd3, 5'd0, 5'd3, 1, 0, 0);
    n_cmp++;
    if (outs !== 6'b110100) begin
      n_bad++; $display("FAIL prio_flush: got %b expected %b", outs, 6'b110100);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (outs !== 6'b110000 || stall !== ex_st(2)) begin
      n_bad++; $display("FAIL prio_idle: got %b/%0d expected %b/%0d", outs, stall, 6'b110000, ex_st(2));
    end
  endtask

  // Random traffic against a rule-level model: mode flags plus a count of
  // unacknowledged WAIT cycles; occasional ack droughts force timeouts.
  task automatic test_random();
    bit   m_err = 0, m_wait = 0;
    int   m_wc = 0, m_stall = 0, drought = 0;
    bit   hz, mf;
    logic [5:0] ex;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      vld = 1'($urandom); mrd = 1'($urandom);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      br  = ($urandom_range(0, 3) == 0);
      req = ($urandom_range(0, 2) == 0);
      if (drought == 0 && $urandom_range(0, 299) == 0) drought = 300;
      if (drought > 0) begin
        ack = 1'b0; drought--;
      end else begin
        ack = ($urandom_range(0, 2) == 0);
      end
      #1;
      hz = vld && mrd && (rd != 0) && (rd == rs1 || rd == rs2);
      mf = m_err || (m_wait ? !ack : (req && !ack));
      if (mf)      ex = {4'b0000, 1'b1, m_err};
      else if (hz) ex = {4'b0010, 1'b0, m_err};
      else if (br) ex = {4'b1101, 1'b0, m_err};
      else         ex = {4'b1100, 1'b0, m_err};
      n_cmp++;
      if (outs !== ex || stall !== (PERF ? CW'(m_stall) : '0)) begin
        n_bad++;
        $display("FAIL random_c%0d: got %b/%0d expected %b/%0d", i, outs, stall, ex,
                 PERF ? m_stall : 0);
      end
      if (!rst_n) begin
        m_err = 0; m_wait = 0; m_wc = 0; m_stall = 0;
      end else begin
        if (!ex[5] && m_stall < (2**CW - 1)) m_stall++;
        if (m_wait) begin
          if (ack) begin
            m_wait = 0; m_wc = 0;
          end else begin
            m_wc++;
            if (m_wc == TO) begin
              m_err = 1; m_wait = 0; m_wc = 0;
            end
          end
        end else if (!m_err && req && !ack) begin
          m_wait = 1; m_wc = 0;
        end
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    apply_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    n = PERF ? 70000 : 300;
    repeat (n) @(negedge clk);
    #1;
    n_cmp++;
    if (outs !== 6'b000011) begin
      n_bad++; $display("FAIL sat_err: got %b expected %b", outs, 6'b000011);
    end
    n_cmp++;
    if (stall !== (PERF ? {CW{1'b1}} : '0)) begin
      n_bad++; $display("FAIL sat_value: got %h expected %h", stall, PERF ? {CW{1'b1}} : {CW{1'b0}});
    end
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (stall !== (PERF ? {CW{1'b1}} : '0)) begin
      n_bad++; $display("FAIL sat_hold: got %h expected %h", stall, PERF ? {CW{1'b1}} : {CW{1'b0}});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vld = 0; mrd = 0; rs1 = 0; rs2 = 0; rd = 0; br = 0; req = 0; ack = 0;
    test_reset();
    test_load_use();
    test_x0_branch();
    test_freeze();
    test_timeout();
    test_priority();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
